mem_access_ctrl: RTL and testbench

- MEM-stage sequencer between the decoded memory controls (read/write/sign-extend flags, byte select, store data) and a variable-latency data RAM port.
- Checks alignment, positions byte lanes, issues one RAM transaction per instruction and stalls the pipeline until the RAM acknowledges or a timeout fires.
- Returns aligned, sign- or zero-extended load data to write-back.

---
 rtl/mem_access_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: aligns and issues one data-RAM transaction per instruction,
// stalls the pipeline until ram_ready or timeout, and returns extended load data.
module mem_access_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_flag,
  input  logic                  mem_write_flag,
  input  logic                  mem_sign_ext_flag,
  input  logic [3:0]            mem_sel,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_write_data,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  input  logic                  ram_ready,
  output logic                  stall_req,
  output logic [31:0]           load_data,
  output logic                  load_valid,
  output logic                  addr_err,
  output logic                  bus_err
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                state_q, state_d;
  logic                  ram_en_q, ram_en_d;
  logic [3:0]            ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]           ram_wdata_q, ram_wdata_d;
  logic [31:0]           load_data_q, load_data_d;
  logic                  load_valid_q, load_valid_d;
  logic                  bus_err_q, bus_err_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  is_write_q, is_write_d;
  logic                  sx_q, sx_d;
  logic [3:0]            sel_q, sel_d;
  logic [1:0]            off_q, off_d;

  logic        req;
  logic        misaligned;
  logic [1:0]  off;
  logic [31:0] shifted;
  logic [31:0] ext_data;

  assign off        = mem_addr[1:0];
  assign req        = (mem_read_flag | mem_write_flag) & (mem_sel != 4'b0000);
  assign misaligned = ((mem_sel == 4'b1111) && (off != 2'b00)) ||
                      ((mem_sel == 4'b0011) && off[0]);

  assign addr_err  = (state_q == StIdle) & req & misaligned;
  assign stall_req = ((state_q == StIdle) & req & ~misaligned) | (state_q == StAccess);

  // Load extraction uses the sel/off latched at issue, not the live pipeline inputs.
  always_comb begin
    shifted  = ram_rdata >> {off_q, 3'b000};
    ext_data = shifted;
    case (sel_q)
      4'b0001: ext_data = {{24{sx_q & shifted[7]}}, shifted[7:0]};
      4'b0011: ext_data = {{16{sx_q & shifted[15]}}, shifted[15:0]};
      default: ext_data = shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ram_en_d     = ram_en_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;
    cnt_d        = cnt_q;
    is_write_d   = is_write_q;
    sx_d         = sx_q;
    sel_d        = sel_q;
    off_d        = off_q;

    case (state_q)
      StIdle: begin
        if (req && !misaligned) begin
          state_d     = StAccess;
          ram_en_d    = 1'b1;
          ram_addr_d  = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
          ram_we_d    = mem_write_flag ? (mem_sel << off) : 4'b0000;
          ram_wdata_d = mem_write_data << {off, 3'b000};
          is_write_d  = mem_write_flag;
          sx_d        = mem_sign_ext_flag;
          sel_d       = mem_sel;
          off_d       = off;
          cnt_d       = 8'd0;
        end
      end
      StAccess: begin
        if (ram_ready) begin
          state_d  = StDone;
          ram_en_d = 1'b0;
          ram_we_d = 4'b0000;
          if (!is_write_q) begin
            load_data_d  = ext_data;
            load_valid_d = 1'b1;
          end
        end else if (cnt_q == TimeoutLast) begin
          state_d     = StDone;
          ram_en_d    = 1'b0;
          ram_we_d    = 4'b0000;
          bus_err_d   = 1'b1;
          load_data_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        // Inputs here still belong to the retiring instruction.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 4'b0000;
      ram_addr_q   <= '0;
      ram_wdata_q  <= 32'd0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      cnt_q        <= 8'd0;
      is_write_q   <= 1'b0;
      sx_q         <= 1'b0;
      sel_q        <= 4'b0000;
      off_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
      cnt_q        <= cnt_d;
      is_write_q   <= is_write_d;
      sx_q         <= sx_d;
      sel_q        <= sel_d;
      off_q        <= off_d;
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with TIMEOUT=4 and hand-computed expectations.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_flag, mem_write_flag, mem_sign_ext_flag;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_write_data;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_ready;
  logic        stall_req;
  logic [31:0] load_data;
  logic        load_valid, addr_err, bus_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .ADDR_WIDTH(32),
    .TIMEOUT   (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_read_flag    (mem_read_flag),
    .mem_write_flag   (mem_write_flag),
    .mem_sign_ext_flag(mem_sign_ext_flag),
    .mem_sel          (mem_sel),
    .mem_addr         (mem_addr),
    .mem_write_data   (mem_write_data),
    .ram_en           (ram_en),
    .ram_we           (ram_we),
    .ram_addr         (ram_addr),
    .ram_wdata        (ram_wdata),
    .ram_rdata        (ram_rdata),
    .ram_ready        (ram_ready),
    .stall_req        (stall_req),
    .load_data        (load_data),
    .load_valid       (load_valid),
    .addr_err         (addr_err),
    .bus_err          (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic sx, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] wdata);
    mem_read_flag     = rd;
    mem_write_flag    = wr;
    mem_sign_ext_flag = sx;
    mem_sel           = sel;
    mem_addr          = addr;
    mem_write_data    = wdata;
    #1;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
  endtask

  // Issue a request and complete it with ram_ready on the first ACCESS cycle; leaves the
  // bench in DONE, with DONE-cycle outputs settled.
  task automatic one_shot(input string tag, input logic rd, input logic wr, input logic sx,
                          input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input logic [3:0] exp_we, input logic [31:0] exp_addr,
                          input logic [31:0] exp_wdata);
    drive(rd, wr, sx, sel, addr, wdata);
    check({tag, ".stall_T"}, 32'(stall_req), 32'd1);
    tick();
    check({tag, ".ram_en"}, 32'(ram_en), 32'd1);
    check({tag, ".ram_we"}, 32'(ram_we), 32'(exp_we));
    check({tag, ".ram_addr"}, ram_addr, exp_addr);
    check({tag, ".ram_wdata"}, ram_wdata, exp_wdata);
    check({tag, ".stall_T1"}, 32'(stall_req), 32'd1);
    ram_rdata = rdata;
    ram_ready = 1'b1;
    tick();
    ram_ready = 1'b0;
    idle_inputs();
    check({tag, ".stall_done"}, 32'(stall_req), 32'd0);
    check({tag, ".ram_en_done"}, 32'(ram_en), 32'd0);
    check({tag, ".ram_we_done"}, 32'(ram_we), 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    ram_rdata = 32'd0;
    ram_ready = 1'b0;
    idle_inputs();
    tick();
    tick();
    check("rst.ram_en", 32'(ram_en), 32'd0);
    check("rst.ram_we", 32'(ram_we), 32'd0);
    check("rst.load_data", load_data, 32'd0);
    check("rst.load_valid", 32'(load_valid), 32'd0);
    check("rst.bus_err", 32'(bus_err), 32'd0);
    check("rst.stall", 32'(stall_req), 32'd0);
    rst = 1'b1;
    tick();

    // Word load with sign-extend flag: full word returned untouched.
    one_shot("wload", 1'b1, 1'b0, 1'b1, 4'b1111, 32'h104, 32'h0, 32'h80FF1234,
             4'b0000, 32'h104, 32'h0);
    check("wload.load_data", load_data, 32'h80FF1234);
    check("wload.load_valid", 32'(load_valid), 32'd1);
    tick();
    check("wload.valid_pulse", 32'(load_valid), 32'd0);

    // Byte loads at offset 3, signed then unsigned.
    one_shot("bload_s", 1'b1, 1'b0, 1'b1, 4'b0001, 32'h203, 32'h0, 32'h9A000000,
             4'b0000, 32'h200, 32'h0);
    check("bload_s.load_data", load_data, 32'hFFFFFF9A);
    check("bload_s.load_valid", 32'(load_valid), 32'd1);
    tick();
    one_shot("bload_u", 1'b1, 1'b0, 1'b0, 4'b0001, 32'h203, 32'h0, 32'h9A000000,
             4'b0000, 32'h200, 32'h0);
    check("bload_u.load_data", load_data, 32'h0000009A);
    tick();

    // Signed half load at offset 2.
    one_shot("hload", 1'b1, 1'b0, 1'b1, 4'b0011, 32'h102, 32'h0, 32'h80010000,
             4'b0000, 32'h100, 32'h0);
    check("hload.load_data", load_data, 32'hFFFF8001);
    tick();

    // Stores: lane shifting, load_data untouched, no load_valid.
    one_shot("bstore", 1'b0, 1'b1, 1'b0, 4'b0001, 32'h12, 32'h000000AB, 32'h55555555,
             4'b0100, 32'h10, 32'h00AB0000);
    check("bstore.load_valid", 32'(load_valid), 32'd0);
    check("bstore.load_data", load_data, 32'hFFFF8001);
    tick();
    one_shot("hstore", 1'b0, 1'b1, 1'b0, 4'b0011, 32'h12, 32'h0000BEEF, 32'h55555555,
             4'b1100, 32'h10, 32'hBEEF0000);
    check("hstore.load_data", load_data, 32'hFFFF8001);
    tick();

    // Both flags set resolves to a write.
    one_shot("rwboth", 1'b1, 1'b1, 1'b0, 4'b1111, 32'h20, 32'hCAFEF00D, 32'h11111111,
             4'b1111, 32'h20, 32'hCAFEF00D);
    check("rwboth.load_valid", 32'(load_valid), 32'd0);
    check("rwboth.load_data", load_data, 32'hFFFF8001);
    tick();

    // Misaligned word and half; sel=0 is not a request.
    drive(1'b1, 1'b0, 1'b0, 4'b1111, 32'h102, 32'h0);
    check("mis_w.addr_err", 32'(addr_err), 32'd1);
    check("mis_w.stall", 32'(stall_req), 32'd0);
    tick();
    check("mis_w.ram_en", 32'(ram_en), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 4'b0011, 32'h101, 32'h0);
    check("mis_h.addr_err", 32'(addr_err), 32'd1);
    check("mis_h.stall", 32'(stall_req), 32'd0);
    tick();
    check("mis_h.ram_en", 32'(ram_en), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 4'b0000, 32'h100, 32'h0);
    check("nosel.stall", 32'(stall_req), 32'd0);
    check("nosel.addr_err", 32'(addr_err), 32'd0);
    tick();
    check("nosel.ram_en", 32'(ram_en), 32'd0);

    // Timeout: four ACCESS cycles without ram_ready, then bus_err in DONE.
    drive(1'b1, 1'b0, 1'b0, 4'b1111, 32'h40, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("tmo.ram_en%0d", i), 32'(ram_en), 32'd1);
      check($sformatf("tmo.stall%0d", i), 32'(stall_req), 32'd1);
    end
    tick();
    idle_inputs();
    check("tmo.ram_en_done", 32'(ram_en), 32'd0);
    check("tmo.bus_err", 32'(bus_err), 32'd1);
    check("tmo.load_valid", 32'(load_valid), 32'd0);
    check("tmo.load_data", load_data, 32'd0);
    check("tmo.stall_done", 32'(stall_req), 32'd0);
    tick();
    check("tmo.bus_err_pulse", 32'(bus_err), 32'd0);

    // Reload something nonzero, then reset during the second ACCESS cycle.
    one_shot("pre_rst", 1'b1, 1'b0, 1'b0, 4'b1111, 32'h80, 32'h0, 32'hDEADBEEF,
             4'b0000, 32'h80, 32'h0);
    check("pre_rst.load_data", load_data, 32'hDEADBEEF);
    tick();
    drive(1'b0, 1'b1, 1'b0, 4'b1111, 32'h84, 32'h12345678);
    tick();
    tick();
    check("mid.ram_en", 32'(ram_en), 32'd1);
    rst = 1'b0;
    tick();
    idle_inputs();
    check("mid.ram_en_rst", 32'(ram_en), 32'd0);
    check("mid.ram_we_rst", 32'(ram_we), 32'd0);
    check("mid.ram_addr_rst", ram_addr, 32'd0);
    check("mid.ram_wdata_rst", ram_wdata, 32'd0);
    check("mid.load_data_rst", load_data, 32'd0);
    check("mid.stall_rst", 32'(stall_req), 32'd0);
    rst       = 1'b1;
    ram_rdata = 32'hFFFFFFFF;
    ram_ready = 1'b1;
    tick();
    ram_ready = 1'b0;
    check("late_ready.ram_en", 32'(ram_en), 32'd0);
    check("late_ready.load_valid", 32'(load_valid), 32'd0);
    check("late_ready.load_data", load_data, 32'd0);

    // Fresh request after reset completes normally.
    one_shot("fresh", 1'b1, 1'b0, 1'b0, 4'b1111, 32'h8, 32'h0, 32'h12345678,
             4'b0000, 32'h8, 32'h0);
    check("fresh.load_data", load_data, 32'h12345678);
    check("fresh.load_valid", 32'(load_valid), 32'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
